// File: rtl/fetch_pc_gen_if.sv
// Fetch PC generator bus: execute-stage redirect inputs, imem request handshake and flush/trap outputs.
// master = PC generator side, slave = surrounding pipeline / imem side.
interface fetch_pc_gen_if #(
  parameter int unsigned ADDR_WIDTH = 64
);
  logic                  redir_valid;
  logic [1:0]            redir_type;
  logic                  br_taken;
  logic [ADDR_WIDTH-1:0] bra_addr;
  logic [ADDR_WIDTH-1:0] jal_addr;
  logic [ADDR_WIDTH-1:0] jalr_addr;
  logic                  stall;
  logic                  fetch_ready;
  logic                  fetch_valid;
  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic                  flush;
  logic                  misalign_exc;
  logic [ADDR_WIDTH-1:0] misalign_pc;

  modport master (
    input  redir_valid, redir_type, br_taken, bra_addr, jal_addr, jalr_addr,
    input  stall, fetch_ready,
    output fetch_valid, fetch_pc, flush, misalign_exc, misalign_pc
  );

  modport slave (
    output redir_valid, redir_type, br_taken, bra_addr, jal_addr, jalr_addr,
    output stall, fetch_ready,
    input  fetch_valid, fetch_pc, flush, misalign_exc, misalign_pc
  );
endinterface

// File: rtl/fetch_pc_gen.sv
// Fetch-stage PC generator: owns the fetch PC, issues imem requests over valid/ready, applies redirects.
// Optional MISALIGN_TRAP_EN: misaligned redirect targets raise misalign_exc instead of redirecting.
module fetch_pc_gen #(
    parameter int unsigned           ADDR_WIDTH = 64,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int unsigned           INST_BYTES = 4
) (
    input logic             clk,
    input logic             rst_n,
    fetch_pc_gen_if.master  bus
);

    typedef enum logic [1:0] {BOOT, RUN, PEND} state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] r_pend_pc;
    logic                  r_valid;
    logic                  r_flush;

    logic                  w_take_raw;
    logic                  w_take;
    logic                  w_hs;
    logic                  w_next_valid;
    logic [ADDR_WIDTH-1:0] w_target;

    always_comb begin
        w_take_raw = 1'b0;
        w_target   = '0;
        if (bus.redir_valid) begin
            case (bus.redir_type)
                2'b01: begin
                    w_take_raw = bus.br_taken;
                    w_target   = bus.bra_addr;
                end
                2'b10: begin
                    w_take_raw = 1'b1;
                    w_target   = bus.jal_addr;
                end
                2'b11: begin
                    w_take_raw = 1'b1;
                    w_target   = bus.jalr_addr;
                end
                default: begin
                    w_take_raw = 1'b0;
                    w_target   = '0;
                end
            endcase
        end
    end

`ifdef MISALIGN_TRAP_EN
    logic                  w_misalign;
    logic                  r_misalign_exc;
    logic [ADDR_WIDTH-1:0] r_misalign_pc;

    assign w_misalign = w_take_raw && (w_target[1:0] != 2'b00);
    assign w_take     = w_take_raw && !w_misalign;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_misalign_exc <= 1'b0;
            r_misalign_pc  <= '0;
        end else begin
            r_misalign_exc <= w_misalign;
            if (w_misalign) r_misalign_pc <= w_target;
        end
    end

    assign bus.misalign_exc = r_misalign_exc;
    assign bus.misalign_pc  = r_misalign_pc;
`else
    assign w_take           = w_take_raw;
    assign bus.misalign_exc = 1'b0;
    assign bus.misalign_pc  = '0;
`endif

    assign w_hs         = r_valid && bus.fetch_ready;
    // A presented request is never retracted; stall only blocks issuing the next one.
    assign w_next_valid = !bus.stall || (r_valid && !w_hs);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= BOOT;
            r_pc      <= RESET_PC;
            r_pend_pc <= '0;
            r_valid   <= 1'b0;
            r_flush   <= 1'b0;
        end else begin
            r_flush <= w_take;
            case (r_state)
                BOOT: begin
                    r_valid <= 1'b1;
                    r_state <= RUN;
                    if (w_take) r_pc <= w_target;
                end
                RUN: begin
                    if (w_take && (w_hs || !r_valid)) begin
                        r_pc <= w_target;
                    end else if (w_take) begin
                        r_pend_pc <= w_target;
                        r_state   <= PEND;
                    end else if (w_hs) begin
                        r_pc <= r_pc + ADDR_WIDTH'(INST_BYTES);
                    end
                    r_valid <= w_next_valid;
                end
                PEND: begin
                    // Latest redirect wins, including one arriving in the same cycle as the handshake.
                    if (w_take) r_pend_pc <= w_target;
                    if (w_hs) begin
                        r_pc    <= w_take ? w_target : r_pend_pc;
                        r_state <= RUN;
                    end
                    r_valid <= w_next_valid;
                end
                default: begin
                    r_state <= BOOT;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.fetch_valid = r_valid;
    assign bus.fetch_pc    = r_pc;
    assign bus.flush       = r_flush;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed self-checking bench for fetch_pc_gen; expected values are hand-computed per step.
// Covers both builds: the final redirect check follows MISALIGN_TRAP_EN.
module tb_fetch_pc_gen;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fetch_pc_gen_if #(.ADDR_WIDTH(64)) bus ();

    fetch_pc_gen #(
        .ADDR_WIDTH(64),
        .RESET_PC  (64'h0),
        .INST_BYTES(4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Unused target fields carry decoys so a wrong mux leg shows up as a wrong PC.
    task automatic redir(input logic [1:0] typ, input logic taken, input logic [63:0] addr);
        bus.redir_valid = 1'b1;
        bus.redir_type  = typ;
        bus.br_taken    = taken;
        bus.bra_addr    = 64'hB0B0_0000;
        bus.jal_addr    = 64'hA0A0_0000;
        bus.jalr_addr   = 64'hC0C0_0000;
        case (typ)
            2'b01:   bus.bra_addr  = addr;
            2'b10:   bus.jal_addr  = addr;
            default: bus.jalr_addr = addr;
        endcase
    endtask

    task automatic no_redir();
        bus.redir_valid = 1'b0;
        bus.redir_type  = 2'b00;
        bus.br_taken    = 1'b0;
    endtask

    task automatic chk_state(input string tag, input logic v, input logic [63:0] pc, input logic fl);
        chk({tag, "_valid"}, 64'(bus.fetch_valid), 64'(v));
        chk({tag, "_pc"},    bus.fetch_pc,         pc);
        chk({tag, "_flush"}, 64'(bus.flush),       64'(fl));
    endtask

    initial begin
        no_redir();
        bus.bra_addr    = '0;
        bus.jal_addr    = '0;
        bus.jalr_addr   = '0;
        bus.stall       = 1'b0;
        bus.fetch_ready = 1'b0;

        // Reset values
        #12;
        chk_state("rst", 1'b0, 64'h0, 1'b0);
        chk("rst_mexc", 64'(bus.misalign_exc), 64'h0);
        chk("rst_mpc",  bus.misalign_pc,       64'h0);
        rst_n = 1'b1;

        // BOOT -> RUN presents RESET_PC
        step();
        chk_state("boot", 1'b1, 64'h0, 1'b0);
        bus.fetch_ready = 1'b1;
        step(); chk_state("seq4", 1'b1, 64'h4, 1'b0);
        step(); chk_state("seq8", 1'b1, 64'h8, 1'b0);

        // imem backpressure at pc=8 for three cycles
        bus.fetch_ready = 1'b0;
        step(); chk_state("hold1", 1'b1, 64'h8, 1'b0);
        step(); chk_state("hold2", 1'b1, 64'h8, 1'b0);
        step(); chk_state("hold3", 1'b1, 64'h8, 1'b0);
        bus.fetch_ready = 1'b1;
        step(); chk_state("seqC", 1'b1, 64'hC, 1'b0);

        // Taken branch with handshake
        redir(2'b01, 1'b1, 64'h100);
        step(); chk_state("br_tk", 1'b1, 64'h100, 1'b1);
        no_redir();
        step(); chk_state("br_after", 1'b1, 64'h104, 1'b0);

        // Not-taken branch
        redir(2'b01, 1'b0, 64'h500);
        step(); chk_state("br_nt", 1'b1, 64'h108, 1'b0);

        // Type 00 ignored
        redir(2'b00, 1'b1, 64'h600);
        bus.redir_type = 2'b00;
        step(); chk_state("ty00", 1'b1, 64'h10C, 1'b0);

        // JALR while blocked -> PEND, then JAL overwrites pending target
        bus.fetch_ready = 1'b0;
        redir(2'b11, 1'b0, 64'h2000);
        step(); chk_state("jalr_pend", 1'b1, 64'h10C, 1'b1);
        redir(2'b10, 1'b0, 64'h3000);
        step(); chk_state("jal_pend", 1'b1, 64'h10C, 1'b1);
        no_redir();
        step(); chk_state("pend_hold", 1'b1, 64'h10C, 1'b0);
        bus.fetch_ready = 1'b1;
        step(); chk_state("pend_hs", 1'b1, 64'h3000, 1'b0);
        step(); chk_state("pend_seq", 1'b1, 64'h3004, 1'b0);

        // Wrap at the top of the address space
        redir(2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8);
        step(); chk_state("wrap_jmp", 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 1'b1);
        no_redir();
        step(); chk_state("wrap_fc", 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
        step(); chk_state("wrap_0", 1'b1, 64'h0, 1'b0);

        // Stall: accepted request is not reissued until stall drops
        bus.stall = 1'b1;
        step(); chk_state("stall_hs", 1'b0, 64'h4, 1'b0);
        step(); chk_state("stall_idle", 1'b0, 64'h4, 1'b0);
        bus.stall = 1'b0;
        step(); chk_state("unstall", 1'b1, 64'h4, 1'b0);
        bus.stall       = 1'b1;
        bus.fetch_ready = 1'b0;
        step(); chk_state("stall_keep", 1'b1, 64'h4, 1'b0);
        bus.fetch_ready = 1'b1;
        step(); chk_state("stall_acc", 1'b0, 64'h8, 1'b0);

        // Redirect while no request is outstanding applies immediately
        redir(2'b11, 1'b0, 64'h4000);
        step(); chk_state("idle_jmp", 1'b0, 64'h4000, 1'b1);
        no_redir();
        bus.stall       = 1'b0;
        bus.fetch_ready = 1'b0;
        step(); chk_state("idle_issue", 1'b1, 64'h4000, 1'b0);

        // Reset in PEND discards the pending target
        redir(2'b10, 1'b0, 64'h700);
        step(); chk_state("rp_pend", 1'b1, 64'h4000, 1'b1);
        no_redir();
        #2 rst_n = 1'b0;
        #1 chk_state("rp_rst", 1'b0, 64'h0, 1'b0);
        #3 rst_n = 1'b1;
        step(); chk_state("rp_boot", 1'b1, 64'h0, 1'b0);
        bus.fetch_ready = 1'b1;
        step(); chk_state("rp_seq", 1'b1, 64'h4, 1'b0);

        // Misaligned JAL target
        redir(2'b10, 1'b0, 64'h102);
        step();
`ifdef MISALIGN_TRAP_EN
        chk_state("mis", 1'b1, 64'h8, 1'b0);
        chk("mis_exc", 64'(bus.misalign_exc), 64'h1);
        chk("mis_pc",  bus.misalign_pc,       64'h102);
        no_redir();
        step();
        chk_state("mis_after", 1'b1, 64'hC, 1'b0);
        chk("mis_exc_off", 64'(bus.misalign_exc), 64'h0);
        chk("mis_pc_hold", bus.misalign_pc,       64'h102);
`else
        chk_state("mis", 1'b1, 64'h102, 1'b1);
        chk("mis_exc", 64'(bus.misalign_exc), 64'h0);
        chk("mis_pc",  bus.misalign_pc,       64'h0);
        no_redir();
        step();
        chk_state("mis_after", 1'b1, 64'h106, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
